cram_loader: RTL and testbench

Bitstream loader and run-control sequencer for a tile's configuration chain.
- Accepts configuration words from a host over a valid/ready interface and serialises them LSB-first onto the `fpgacell` serial CRAM chain, pulsing `config_en` once per bit.
- Holds the configurable logic disabled and in reset while loading; releases it once exactly `CHAIN_LEN` bits have been shifted.
- Optional verify pass compares the chain's tail output against the stream being shifted in.

---
 rtl/cram_loader.sv | 109 ++++++++++
 tb/tb_cram_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cram_loader.sv
// Bitstream loader for a tile's serial CRAM chain: accepts host words, shifts them
// LSB-first with one config_en per bit, then releases the fabric once the chain is full.
module cram_loader #(
   parameter int CHAIN_LEN  = 1024,
   parameter int WORD_WIDTH = 8,
   parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  verify,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  cfg_data,
   output logic                  cfg_en,
   input  logic                  cfg_tail,
   output logic                  fabric_en,
   output logic                  fabric_nrst,
   output logic                  busy,
   output logic                  done,
   output logic                  verify_err,
   output logic [CNT_W-1:0]      bit_count
);

   localparam int IDX_W = $clog2(WORD_WIDTH + 1);
   localparam logic [CNT_W-1:0] LP_CHAIN = CNT_W'(CHAIN_LEN);
   localparam logic [IDX_W-1:0] LP_WORD  = IDX_W'(WORD_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEPT = 2'd1,
      S_SHIFT  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   logic [WORD_WIDTH-1:0] r_buf;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_vmode;
   logic                  r_verr;

   wire [CNT_W-1:0] w_cnt_nxt = r_cnt + CNT_W'(1);
   wire [IDX_W-1:0] w_idx_nxt = r_idx + IDX_W'(1);

   // Load sequencer: the chain length check wins over the word-boundary check so a
   // partial final word is truncated rather than shifted past the end of the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_vmode <= 1'b0;
         r_verr  <= 1'b0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_vmode <= verify;
                  r_cnt   <= '0;
                  r_verr  <= 1'b0;
                  r_state <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  r_buf   <= in_data;
                  r_idx   <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_buf <= r_buf >> 1;
               r_idx <= w_idx_nxt;
               r_cnt <= w_cnt_nxt;
               if (r_vmode && (cfg_tail != r_buf[0])) begin
                  r_verr <= 1'b1;
               end
               if (w_cnt_nxt == LP_CHAIN) begin
                  r_state <= S_DONE;
               end else if (w_idx_nxt == LP_WORD) begin
                  r_state <= S_ACCEPT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; no path from in_data reaches the chain.
   assign in_ready    = (r_state == S_ACCEPT);
   assign cfg_en      = (r_state == S_SHIFT);
   assign cfg_data    = (r_state == S_SHIFT) & r_buf[0];
   assign busy        = (r_state == S_ACCEPT) | (r_state == S_SHIFT);
   assign done        = (r_state == S_DONE);
   assign fabric_en   = (r_state == S_DONE);
   assign fabric_nrst = (r_state == S_DONE);
   assign verify_err  = r_verr;
   assign bit_count   = r_cnt;

endmodule

// File: tb/tb_cram_loader.sv
// Self-checking bench for cram_loader with a 20-bit behavioural CRAM chain and a
// stream-level reference (words concatenated LSB-first, truncated to the chain length).
module tb_cram_loader;

   localparam int CL = 20;
   localparam int WW = 8;
   localparam int CW = $clog2(CL + 1);

   logic          clk = 1'b0;
   logic          rst, start, verify, abort, in_valid;
   logic [WW-1:0] in_data;
   logic          in_ready, cfg_data, cfg_en, cfg_tail;
   logic          fabric_en, fabric_nrst, busy, done, verify_err;
   logic [CW-1:0] bit_count;

   int checks   = 0;
   int failures = 0;

   logic [CL-1:0] chain = '0;
   bit            flip_req = 1'b0;
   bit            flip_ack = 1'b0;
   logic [CL-1:0] ref_chain = '0;
   bit            ref_valid = 1'b1;

   cram_loader #(.CHAIN_LEN(CL), .WORD_WIDTH(WW)) dut (
      .clk(clk), .rst(rst), .start(start), .verify(verify), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cfg_data(cfg_data), .cfg_en(cfg_en), .cfg_tail(cfg_tail),
      .fabric_en(fabric_en), .fabric_nrst(fabric_nrst), .busy(busy), .done(done),
      .verify_err(verify_err), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   // Behavioural CRAM chain: shifts on config_en, tail is the oldest bit.
   always @(posedge clk) begin
      if (cfg_en) chain <= {chain[CL-2:0], cfg_data};
      else if (flip_req != flip_ack) begin
         chain[13] <= ~chain[13];
         flip_ack  <= flip_req;
      end
   end
   assign cfg_tail = chain[CL-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CL-1:0] stream_of(input logic [7:0] a, b, c);
      logic [23:0] t;
      t = {c, b, a};
      return t[CL-1:0];
   endfunction

   function automatic logic [CL-1:0] rev(input logic [CL-1:0] s);
      logic [CL-1:0] r;
      for (int k = 0; k < CL; k++) r[CL-1-k] = s[k];
      return r;
   endfunction

   task automatic run_load(input logic [7:0] w0, w1, w2, input bit vm,
                           input int stall, input int abort_at, input int mstart_at);
      logic [7:0]    words[3];
      logic [CL-1:0] exp_s, obs;
      int            pulses = 0, w = 0, st = stall, first_cyc = -1;
      bit            prev_en = 1'b0, fin = 1'b0, aborted = 1'b0, hs;
      words[0] = w0; words[1] = w1; words[2] = w2;
      exp_s = stream_of(w0, w1, w2);
      obs   = '0;
      start = 1'b1; verify = vm;
      @(negedge clk);
      start = 1'b0;
      chk("accept_ready", in_ready, 1);
      chk("fabric_off_before_shift", {fabric_en, fabric_nrst}, 0);
      chk("no_en_in_accept", cfg_en, 0);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         if (done) begin
            chk("done_after_last_pulse", prev_en, 1);
            fin = 1'b1;
         end else begin
            if (abort_at != 0 && cfg_en && bit_count == CW'(abort_at)) begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               chk("abort_cnt", bit_count, 0);
               chk("abort_busy", busy, 0);
               chk("abort_fabric", {fabric_en, fabric_nrst}, 0);
               for (int i = 0; i < 5; i++) begin
                  chk("abort_no_en", cfg_en, 0);
                  @(negedge clk);
               end
               aborted = 1'b1;
               break;
            end
            if (cfg_en) begin
               if (first_cyc < 0) first_cyc = cyc;
               if (pulses < CL) obs[pulses] = cfg_data;
               pulses++;
            end
            if (w == 1 && in_ready && st > 0) begin
               st--;
               in_valid = 1'b0;
               chk("stall_no_en", cfg_en, 0);
               chk("stall_cnt_hold", bit_count, WW);
            end else if (w < 3) begin
               in_valid = 1'b1;
               in_data  = words[w];
            end else begin
               in_valid = 1'b0;
            end
            hs      = in_ready && in_valid;
            start   = (mstart_at != 0 && cfg_en && bit_count == CW'(mstart_at));
            prev_en = cfg_en;
            @(negedge clk);
            if (hs) w++;
         end
      end
      start = 1'b0; in_valid = 1'b0;
      if (aborted) begin
         ref_valid = 1'b0;
      end else begin
         chk("load_timeout", fin, 1);
         chk("first_en_latency", first_cyc, 1);
         chk("pulse_count", pulses, CL);
         chk("stream", obs, exp_s);
         chk("done_fabric", {done, fabric_en, fabric_nrst, busy}, 4'b1110);
         chk("bit_count_final", bit_count, CL);
         if (!vm || ref_valid)
            chk("verify_err", verify_err, vm && (ref_chain != exp_s));
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_en_after_done", cfg_en, 0);
         end
         chk("chain_contents", chain, rev(exp_s));
         ref_chain = exp_s;
         ref_valid = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] a, b, c;
      rst = 1'b1; start = 1'b0; verify = 1'b0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {in_ready, cfg_data, cfg_en, fabric_en, fabric_nrst, busy, done, verify_err}, 0);
      chk("rst_count", bit_count, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", {in_ready, cfg_en, fabric_en, fabric_nrst, busy, done}, 0);

      run_load(8'hA5, 8'h3C, 8'h0F, 1'b0, 0, 0, 0);
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b0, 5, 0, 0);
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b1, 0, 0, 0);
      chk("verify_clean", verify_err, 0);

      flip_req = ~flip_req;
      @(negedge clk);
      @(negedge clk);
      ref_chain[6] = ~ref_chain[6];
      run_load(8'hA5, 8'h3C, 8'h0F, 1'b1, 0, 0, 0);
      chk("verify_flip_sticky", verify_err, 1);

      run_load(8'h5A, 8'hC3, 8'hF0, 1'b0, 0, 0, 9);
      run_load(8'h12, 8'h34, 8'h56, 1'b0, 0, 11, 0);
      run_load(8'h12, 8'h34, 8'h56, 1'b0, 0, 0, 0);

      a = 8'h00; b = 8'h00; c = 8'h00;
      for (int it = 0; it < 6; it++) begin
         if (it == 0 || $urandom_range(0, 1) == 0) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
         end
         run_load(a, b, c, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0);
      end

      start = 1'b1; verify = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = ~ref_chain[7:0];
      for (int i = 0; i < 20 && bit_count != CW'(5); i++) @(negedge clk);
      chk("pre_rst_cnt", bit_count, 5);
      chk("pre_rst_verr", verify_err, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outputs", {in_ready, cfg_data, cfg_en, fabric_en, fabric_nrst, busy, done, verify_err}, 0);
      chk("rst_mid_count", bit_count, 0);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
